hps_pio_master: RTL and testbench
=================================

# hps_pio_master

Avalon-MM master that drives the PIO-style register slaves in the HPS bridge subsystem from FPGA fabric logic. Fabric clients push single read or write commands through a valid/ready port into a small command FIFO. The block replays them in order as single-cycle chipselect transactions using the legacy active-low strobe style (chipselect, write_n, read_n). Read data is captured after a fixed slave read latency and returned as a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 2, slave word address width
- DATA_W, 32, data width
- READ_LATENCY, 0, slave read latency in cycles; legal 0..3; 0 means readdata is valid in the strobe cycle
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full; a command is accepted on an edge where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  target word address
- cmd_writedata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse carrying read data; no backpressure
- rsp_readdata  out  DATA_W  captured read data; holds until the next capture
- avm_address  out  ADDR_W  slave address
- avm_chipselect  out  1  transaction strobe
- avm_write_n  out  1  active-low write strobe
- avm_read_n  out  1  active-low read strobe
- avm_writedata  out  DATA_W  slave write data
- avm_readdata  in  DATA_W  slave read data
- busy  out  1  FIFO non-empty or FSM not in IDLE

## Operation
- The FIFO stores {write, address, writedata} and preserves order. cmd_ready = !full, combinational from the FIFO count.
- When the FIFO is full, no push occurs even if a pop happens in the same cycle. A simultaneous push and pop when not full leaves the count unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and load the bus registers, then go to ISSUE. Otherwise hold.
  - ISSUE: avm_chipselect = 1 for exactly this cycle. avm_write_n = 0 for a write, avm_read_n = 0 for a read.
    - Write, or read with READ_LATENCY = 0 (avm_readdata sampled at the end of this cycle): if the FIFO is non-empty, pop and stay in ISSUE (back-to-back). Otherwise go to IDLE.
    - Read with READ_LATENCY > 0: clear the counter and go to RWAIT.
  - RWAIT: strobes are inactive. The counter increments each cycle.
    - When the counter reaches READ_LATENCY − 1, capture avm_readdata at that edge.
    - Then pop and go to ISSUE if the FIFO is non-empty, else go to IDLE.
- Outside ISSUE: chipselect = 0, write_n = 1, read_n = 1. Address and writedata hold their last values.
- Read response: rsp_readdata is loaded at the capture edge. rsp_valid = 1 for the single following cycle.
- Writes produce no response.

## Timing
- Reset values:
  - avm_chipselect 0, avm_write_n 1, avm_read_n 1
  - avm_address 0, avm_writedata 0
  - rsp_valid 0, rsp_readdata 0, busy 0
  - cmd_ready 1; FSM in IDLE; FIFO empty
- All bus outputs and rsp_* are registered.
- Command accepted at edge E0 into an empty FIFO with the FSM in IDLE: chipselect is high in the cycle following E1 (2 edges after acceptance).
- Read: sampled at the end of the strobe cycle + READ_LATENCY cycles. rsp_valid is high in the next cycle.
- Throughput:
  - Writes and RL=0 reads: 1 transaction per cycle when the FIFO stays fed.
  - Reads with RL>0: 1 per (1 + READ_LATENCY) cycles.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). The FIFO is flushed. An in-flight read produces no rsp_valid.
- busy deasserts in the cycle after the last ISSUE, or after the last RWAIT capture.

## Test plan
- Single write, addr 0, data 0x000000A5, slave is an 8-bit PIO model -> exactly one cycle with chipselect=1 and write_n=0, 2 cycles after acceptance; slave out_port = 0xA5; no rsp_valid.
- Read after write, RL=0, addr 0 -> read_n=0 for one cycle; rsp_valid one-cycle pulse with rsp_readdata = 0x000000A5; address 1 read returns 0x00000000.
- 4 back-to-back writes 0x11, 0x22, 0x33, 0x44 with RL=0 -> 4 consecutive chipselect cycles in order; busy drops after the fourth strobe.
- Fill FIFO (4 commands) while cmd_valid is held -> cmd_ready=0 with count 4; the fifth command is accepted only after the first pop; all 5 are issued in order.
- READ_LATENCY=2, read then write -> write strobe appears exactly 3 cycles after the read strobe; rsp_valid follows the capture edge.
- Assert reset_n=0 during RWAIT of a pending read with 2 queued writes -> strobes go inactive immediately; no rsp_valid; no queued write is issued after release; cmd_ready=1.

Source files
------------

// File: rtl/hps_pio_master_if.sv
// Command/response port and legacy-strobe Avalon-MM bus of hps_pio_master.
// The master modport is the block's view; the slave modport is the surrounding fabric/slave view.
interface hps_pio_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_readdata;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata, avm_readdata,
        output cmd_ready, rsp_valid, rsp_readdata, avm_address, avm_chipselect,
               avm_write_n, avm_read_n, avm_writedata, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata, avm_readdata,
        input  cmd_ready, rsp_valid, rsp_readdata, avm_address, avm_chipselect,
               avm_write_n, avm_read_n, avm_writedata, busy
    );
endinterface

// File: rtl/hps_pio_master.sv
// Replays queued single read/write commands as one-cycle chipselect transactions
// on a PIO-style slave, returning read data after a fixed slave latency.
module hps_pio_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    hps_pio_master_if.master bus
);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int ENT_W      = 1 + ADDR_W + DATA_W;
    localparam int LAT_LAST_I = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [1:0]       LAT_LAST = 2'(LAT_LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_lat_cnt;
    logic              r_cur_write;
    logic              r_chipselect;
    logic              r_write_n;
    logic              r_read_n;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writedata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_readdata;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_lat_clr;
    logic              w_head_write;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = bus.cmd_valid && !w_full;
    assign {w_head_write, w_head_addr, w_head_data} = r_fifo[r_rptr];

    // Command storage; occupancy is tracked by r_count so the entries need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {bus.cmd_write, bus.cmd_address, bus.cmd_writedata};
        end
    end

    // FIFO pointers and occupancy; a push is refused while full even if a pop happens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, FIFO pop and read-capture decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_lat_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!r_cur_write && (READ_LATENCY > 0)) begin
                    w_lat_clr   = 1'b1;
                    w_state_nxt = ST_RWAIT;
                end else begin
                    w_capture   = !r_cur_write;
                    w_pop       = !w_empty;
                    w_state_nxt = w_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_RWAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_capture   = 1'b1;
                    w_pop       = !w_empty;
                    w_state_nxt = w_empty ? ST_IDLE : ST_ISSUE;
                end else begin
                    w_state_nxt = ST_RWAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus strobes are asserted for the single cycle after a pop; address/data hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_read_n     <= 1'b1;
            r_address    <= {ADDR_W{1'b0}};
            r_writedata  <= {DATA_W{1'b0}};
            r_cur_write  <= 1'b0;
            r_lat_cnt    <= 2'd0;
        end else begin
            r_chipselect <= w_pop;
            r_write_n    <= !(w_pop && w_head_write);
            r_read_n     <= !(w_pop && !w_head_write);
            if (w_pop) begin
                r_address   <= w_head_addr;
                r_cur_write <= w_head_write;
            end
            if (w_pop && w_head_write) begin
                r_writedata <= w_head_data;
            end
            if (w_lat_clr) begin
                r_lat_cnt <= 2'd0;
            end else if (r_state == ST_RWAIT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end
        end
    end

    // Read response: data captured at the sampling edge, valid for the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_readdata <= {DATA_W{1'b0}};
        end else begin
            r_rsp_valid <= w_capture;
            if (w_capture) begin
                r_rsp_readdata <= bus.avm_readdata;
            end
        end
    end

    assign bus.cmd_ready      = !w_full;
    assign bus.busy           = !w_empty || (r_state != ST_IDLE);
    assign bus.avm_chipselect = r_chipselect;
    assign bus.avm_write_n    = r_write_n;
    assign bus.avm_read_n     = r_read_n;
    assign bus.avm_address    = r_address;
    assign bus.avm_writedata  = r_writedata;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_readdata   = r_rsp_readdata;
endmodule

// File: tb/tb_hps_pio_master.sv
// Drives two hps_pio_master instances (slave read latency 0 and 2) against 8-bit PIO
// slave models and compares bus activity and responses with an in-order reference model.
module tb_hps_pio_master;
    localparam int RL0 = 0;
    localparam int RL1 = 2;
    localparam logic [31:0] BAD = 32'hDEADBEEF;

    typedef struct { int k; bit w; logic [1:0] a; logic [31:0] d; } txn_t;
    typedef struct { int k; int c; logic [31:0] d; } rsp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc = 0;
    int   waited_last = 0;
    int   strobe_r = 0;
    logic [31:0] exp_val = 32'd0;
    txn_t exp_q[$];
    rsp_t rsp_q[$];
    int   log_q0[$];
    int   log_q1[$];
    int   last_rsp_cyc[2];
    logic [7:0] mreg [2][4];
    logic [7:0] sreg [2][4];
    logic [1:0] slat_a;
    logic [1:0] svld;

    logic        cs[2], wn[2], rn[2], rv[2], bz[2], rdy[2];
    logic [1:0]  ad[2];
    logic [31:0] wd[2], rdd[2];

    hps_pio_master_if #(.ADDR_W(2), .DATA_W(32)) bus0 ();
    hps_pio_master_if #(.ADDR_W(2), .DATA_W(32)) bus1 ();

    hps_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(RL0), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    hps_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(RL1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    always #5 clk = ~clk;

    always_comb begin
        cs[0]  = bus0.avm_chipselect; cs[1]  = bus1.avm_chipselect;
        wn[0]  = bus0.avm_write_n;    wn[1]  = bus1.avm_write_n;
        rn[0]  = bus0.avm_read_n;     rn[1]  = bus1.avm_read_n;
        ad[0]  = bus0.avm_address;    ad[1]  = bus1.avm_address;
        wd[0]  = bus0.avm_writedata;  wd[1]  = bus1.avm_writedata;
        rv[0]  = bus0.rsp_valid;      rv[1]  = bus1.rsp_valid;
        rdd[0] = bus0.rsp_readdata;   rdd[1] = bus1.rsp_readdata;
        bz[0]  = bus0.busy;           bz[1]  = bus1.busy;
        rdy[0] = bus0.cmd_ready;      rdy[1] = bus1.cmd_ready;
    end

    // PIO slaves: address 1 is an input port tied low, others are 8-bit registers.
    assign bus0.avm_readdata = (bus0.avm_chipselect && !bus0.avm_read_n)
        ? ((bus0.avm_address == 2'd1) ? 32'd0 : {24'd0, sreg[0][bus0.avm_address]}) : BAD;
    assign bus1.avm_readdata = svld[1]
        ? ((slat_a == 2'd1) ? 32'd0 : {24'd0, sreg[1][slat_a]}) : BAD;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    sreg[k][i] <= 8'd0;
                end
            end
            svld   <= 2'd0;
            slat_a <= 2'd0;
        end else begin
            if (bus0.avm_chipselect && !bus0.avm_write_n && bus0.avm_address != 2'd1)
                sreg[0][bus0.avm_address] <= bus0.avm_writedata[7:0];
            if (bus1.avm_chipselect && !bus1.avm_write_n && bus1.avm_address != 2'd1)
                sreg[1][bus1.avm_address] <= bus1.avm_writedata[7:0];
            svld <= {svld[0], bus1.avm_chipselect && !bus1.avm_read_n};
            if (bus1.avm_chipselect && !bus1.avm_read_n)
                slat_a <= bus1.avm_address;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending command of that instance.
    always @(negedge clk) begin
        int  idx;
        bit  hit;
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                if (cs[k]) begin
                    idx = -1;
                    foreach (exp_q[i]) begin
                        if (idx < 0 && exp_q[i].k == k) idx = i;
                    end
                    chk($sformatf("strobe_expected_%0d", k), 32'(idx >= 0), 32'd1);
                    if (idx >= 0) begin
                        chk($sformatf("write_n_%0d", k), 32'(wn[k]), 32'(!exp_q[idx].w));
                        chk($sformatf("read_n_%0d", k), 32'(rn[k]), 32'(exp_q[idx].w));
                        chk($sformatf("address_%0d", k), 32'(ad[k]), 32'(exp_q[idx].a));
                        if (exp_q[idx].w)
                            chk($sformatf("writedata_%0d", k), wd[k], exp_q[idx].d);
                        else
                            rsp_q.push_back('{k, cyc + ((k == 0) ? RL0 : RL1) + 1, exp_q[idx].d});
                        if (k == 0) log_q0.push_back(cyc); else log_q1.push_back(cyc);
                        exp_q.delete(idx);
                    end
                end else begin
                    chk($sformatf("idle_strobes_%0d", k), 32'({wn[k], rn[k]}), 32'd3);
                end
                idx = -1;
                foreach (rsp_q[i]) begin
                    if (idx < 0 && rsp_q[i].k == k) idx = i;
                end
                hit = 1'b0;
                if (idx >= 0) hit = (rsp_q[idx].c == cyc);
                chk($sformatf("rsp_valid_%0d", k), 32'(rv[k]), 32'(hit));
                if (hit) begin
                    chk($sformatf("rsp_readdata_%0d", k), rdd[k], rsp_q[idx].d);
                    last_rsp_cyc[k] <= cyc;
                end
                if (idx >= 0) begin
                    if (rsp_q[idx].c <= cyc) rsp_q.delete(idx);
                end
            end
        end
    end

    task automatic drive(input int k, input bit v, input bit w, input logic [1:0] a, input logic [31:0] d);
        if (k == 0) begin
            bus0.cmd_valid = v; bus0.cmd_write = w; bus0.cmd_address = a; bus0.cmd_writedata = d;
        end else begin
            bus1.cmd_valid = v; bus1.cmd_write = w; bus1.cmd_address = a; bus1.cmd_writedata = d;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    // Offer one command, wait (bounded) for acceptance and record it in the reference model.
    task automatic send(input int k, input bit w, input logic [1:0] a, input logic [31:0] d);
        int waited = 0;
        @(negedge clk); #1;
        drive(k, 1'b1, w, a, d);
        while (!rdy[k] && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("accept_timeout", 32'(rdy[k]), 32'd1);
        acc = cyc + 1;
        waited_last = waited;
        if (rdy[k]) begin
            if (w) begin
                if (a != 2'd1) mreg[k][a] = d[7:0];
                exp_q.push_back('{k, 1'b1, a, d});
            end else begin
                exp_q.push_back('{k, 1'b0, a, (a == 2'd1) ? 32'd0 : {24'd0, mreg[k][a]}});
            end
        end
        @(posedge clk); #1;
        drive(k, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mreg[k][i] = 8'd0;
            drive(k, 1'b0, 1'b0, 2'd0, 32'd0);
        end
        wait_cycles(3);
        for (int k = 0; k < 2; k++) begin
            chk("rst_chipselect", 32'(cs[k]), 32'd0);
            chk("rst_strobes_n", 32'({wn[k], rn[k]}), 32'd3);
            chk("rst_address", 32'(ad[k]), 32'd0);
            chk("rst_writedata", wd[k], 32'd0);
            chk("rst_rsp_valid", 32'(rv[k]), 32'd0);
            chk("rst_rsp_readdata", rdd[k], 32'd0);
            chk("rst_busy", 32'(bz[k]), 32'd0);
            chk("rst_cmd_ready", 32'(rdy[k]), 32'd1);
        end
        reset_n = 1'b1;

        // Single write: strobe two edges after acceptance, slave register updated.
        log_q0.delete();
        send(0, 1'b1, 2'd0, 32'h0000_00A5);
        wait_cycles(4);
        chk("wr_strobe_count", 32'(log_q0.size()), 32'd1);
        if (log_q0.size() > 0) chk("wr_latency", 32'(log_q0[0]), 32'(acc + 1));
        chk("pio_out_port", 32'(sreg[0][0]), 32'h0000_00A5);

        // RL=0 reads of the data register and the tied-low input port.
        send(0, 1'b0, 2'd0, 32'd0);
        wait_cycles(4);
        chk("rd0_data", rdd[0], 32'h0000_00A5);
        chk("rd0_rsp_timing", 32'(last_rsp_cyc[0]), 32'(log_q0[$] + 1));
        send(0, 1'b0, 2'd1, 32'hFFFF_FFFF);
        wait_cycles(4);
        chk("rd1_data", rdd[0], 32'd0);

        // Four back-to-back writes issue on consecutive cycles; busy drops after the last.
        log_q0.delete();
        send(0, 1'b1, 2'd0, 32'h11);
        send(0, 1'b1, 2'd0, 32'h22);
        send(0, 1'b1, 2'd0, 32'h33);
        send(0, 1'b1, 2'd0, 32'h44);
        wait_cycles(2);
        chk("b2b_last_strobe", 32'(cs[0]), 32'd1);
        chk("b2b_busy_during", 32'(bz[0]), 32'd1);
        wait_cycles(1);
        chk("b2b_busy_after", 32'(bz[0]), 32'd0);
        chk("b2b_strobe_count", 32'(log_q0.size()), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (log_q0.size() > i) chk("b2b_spacing", 32'(log_q0[i] - log_q0[i-1]), 32'd1);
        end
        chk("b2b_out_port", 32'(sreg[0][0]), 32'h44);

        // Fill the RL=2 instance's FIFO while valid is held.
        send(1, 1'b0, 2'd0, 32'd0);
        send(1, 1'b0, 2'd2, 32'd0);
        send(1, 1'b1, 2'd2, 32'h61);
        send(1, 1'b1, 2'd3, 32'h62);
        send(1, 1'b1, 2'd2, 32'h63);
        send(1, 1'b1, 2'd0, 32'h64);
        @(negedge clk); #1;
        chk("full_cmd_ready", 32'(rdy[1]), 32'd0);
        chk("full_busy", 32'(bz[1]), 32'd1);
        send(1, 1'b1, 2'd3, 32'h65);
        chk("fifth_waited", 32'(waited_last > 0), 32'd1);
        wait_cycles(30);

        // RL=2: read then write are three cycles apart; response lands with the write strobe.
        log_q1.delete();
        exp_val = {24'd0, mreg[1][2]};
        send(1, 1'b0, 2'd2, 32'd0);
        send(1, 1'b1, 2'd3, 32'h5A);
        wait_cycles(10);
        chk("rl2_strobe_count", 32'(log_q1.size()), 32'd2);
        if (log_q1.size() == 2) begin
            chk("rl2_rd_to_wr", 32'(log_q1[1] - log_q1[0]), 32'd3);
            chk("rl2_rsp_timing", 32'(last_rsp_cyc[1]), 32'(log_q1[0] + 3));
        end
        chk("rl2_rsp_data", rdd[1], exp_val);

        // Reset during RWAIT with two writes queued.
        log_q1.delete();
        send(1, 1'b0, 2'd3, 32'd0);
        send(1, 1'b1, 2'd0, 32'h71);
        send(1, 1'b1, 2'd2, 32'h72);
        strobe_r = log_q1.size();
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_chipselect", 32'(cs[1]), 32'd0);
        chk("mid_rst_strobes_n", 32'({wn[1], rn[1]}), 32'd3);
        chk("mid_rst_busy", 32'(bz[1]), 32'd0);
        chk("mid_rst_cmd_ready", 32'(rdy[1]), 32'd1);
        exp_q.delete();
        rsp_q.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mreg[k][i] = 8'd0;
        end
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(10);
        chk("post_rst_strobes", 32'(log_q1.size()), 32'(strobe_r));
        chk("post_rst_rsp_valid", 32'(rv[1]), 32'd0);
        chk("post_rst_cmd_ready", 32'(rdy[1]), 32'd1);

        // Randomised traffic to both instances.
        for (int n = 0; n < 60; n++) begin
            send($urandom_range(1, 0), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), $urandom);
            if ($urandom_range(3, 0) == 0) wait_cycles($urandom_range(3, 1));
        end
        wait_cycles(40);
        chk("drain_cmds", 32'(exp_q.size()), 32'd0);
        chk("drain_rsps", 32'(rsp_q.size()), 32'd0);
        chk("drain_busy0", 32'(bz[0]), 32'd0);
        chk("drain_busy1", 32'(bz[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
